// File: rtl/avl_st_pkg.sv
// Shared Avalon-ST helpers: narrower FSM states plus the slice-count and
// output-empty arithmetic for splitting one wide beat into narrow slices.
package avl_st_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } narrower_state_t;

  // Number of narrow slices that carry real bytes for one buffered wide beat.
  function automatic int slice_count(logic eop, int empty, int word_in, int word_out);
    int bytes;
    if (!eop) return word_in / word_out;
    bytes = word_in - empty;
    if (bytes < 1) bytes = 1;
    return (bytes + word_out - 1) / word_out;
  endfunction

  // Unused trailing bytes of the final narrow slice; zero for non-eop beats.
  function automatic int out_empty(logic eop, int empty, int word_in, int word_out);
    int bytes;
    if (!eop) return 0;
    bytes = word_in - empty;
    if (bytes < 1) bytes = 1;
    return slice_count(eop, empty, word_in, word_out) * word_out - bytes;
  endfunction

endpackage

// File: rtl/ast_width_narrower_slice_mux.sv
// ast_slice_mux: selects the idx-th DATA_OUT_W slice of the buffered wide word.
module ast_slice_mux #(
  parameter int DATA_IN_W  = 256,
  parameter int DATA_OUT_W = 64,
  parameter int IDX_W      = 2
) (
  input  logic [DATA_IN_W-1:0]  data_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic [DATA_OUT_W-1:0] data_o
);

  localparam int RATIO = DATA_IN_W / DATA_OUT_W;

  // One-hot style compare keeps the select free of a variable-width multiply.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx_i == IDX_W'(i)) data_o = data_i[i*DATA_OUT_W +: DATA_OUT_W];
    end
  end

endmodule

// File: rtl/ast_width_narrower.sv
// ast_width_narrower: Avalon-ST wide-to-narrow beat serialiser.
// Optional protocol checker enabled by defining AST_WIDTH_NARROWER_ERR_EN
// (adds sticky ast_err_o and drops offending beats).
//
// state | meaning
// IDLE  | buffer empty, sink ready, no output
// SEND  | buffered beat being emitted slice by slice
module ast_width_narrower
  import avl_st_pkg::*;
#(
  parameter int DATA_IN_W   = 256,
  parameter int EMPTY_IN_W  = ((DATA_IN_W / 8) > 1) ? $clog2(DATA_IN_W / 8) : 1,
  parameter int CHANNEL_W   = 10,
  parameter int DATA_OUT_W  = 64,
  parameter int EMPTY_OUT_W = ((DATA_OUT_W / 8) > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
`ifdef AST_WIDTH_NARROWER_ERR_EN
  ,
  output logic                   ast_err_o
`endif
);

  localparam int WORD_IN  = DATA_IN_W / 8;
  localparam int WORD_OUT = DATA_OUT_W / 8;
  localparam int RATIO    = DATA_IN_W / DATA_OUT_W;
  localparam int IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

  narrower_state_t state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [DATA_IN_W-1:0]  buf_data;
  logic                  buf_sop;
  logic                  buf_eop;
  logic [EMPTY_IN_W-1:0] buf_empty;
  logic [CHANNEL_W-1:0]  buf_channel;
  int                    n_slices;
  logic                  last_slice;
  logic                  ready_base;
  logic                  accept;
  logic                  load;
  logic                  drop;
  logic                  sending;

  // Slice count of the buffered beat decides where the eop slice lands.
  always_comb n_slices = slice_count(buf_eop, int'(buf_empty), WORD_IN, WORD_OUT);

  assign sending    = (state == SEND);
  assign last_slice = (idx == IDX_W'(n_slices - 1));
  // Combinational from ast_ready_i so a new beat loads as the last slice leaves.
  assign ready_base = srst_i && ((state == IDLE) || (ast_ready_i && last_slice));
  assign accept     = ast_valid_i && ast_ready_o;
  assign load       = accept && !drop;

`ifdef AST_WIDTH_NARROWER_ERR_EN
  logic in_pkt;
  logic bad_beat;

  assign bad_beat = ast_valid_i &&
                    ((ast_startofpacket_i && in_pkt) ||
                     (!ast_startofpacket_i && !in_pkt) ||
                     (ast_endofpacket_i && (int'(ast_empty_i) >= WORD_IN)));
  // Offending beats are swallowed immediately so the sink never stalls on them.
  assign ast_ready_o = ready_base || (srst_i && bad_beat);
  assign drop        = bad_beat;

  // Packet-framing tracker and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      in_pkt    <= 1'b0;
      ast_err_o <= 1'b0;
    end else if (accept) begin
      if (bad_beat) ast_err_o <= 1'b1;
      else          in_pkt    <= !ast_endofpacket_i;
    end
  end
`else
  assign ast_ready_o = ready_base;
  assign drop        = 1'b0;
`endif

  // FSM state and slice index register.
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next state: advance a slice per taken output, reload or idle after the last.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = SEND;
          idx_nxt   = '0;
        end
      end
      SEND: begin
        if (ast_ready_i) begin
          if (last_slice) begin
            idx_nxt   = '0;
            state_nxt = load ? SEND : IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Wide beat buffer with its framing side-band.
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      buf_data    <= '0;
      buf_sop     <= 1'b0;
      buf_eop     <= 1'b0;
      buf_empty   <= '0;
      buf_channel <= '0;
    end else if (load) begin
      buf_data    <= ast_data_i;
      buf_sop     <= ast_startofpacket_i;
      buf_eop     <= ast_endofpacket_i;
      buf_empty   <= ast_empty_i;
      buf_channel <= ast_channel_i;
    end
  end

  ast_slice_mux #(
    .DATA_IN_W (DATA_IN_W),
    .DATA_OUT_W(DATA_OUT_W),
    .IDX_W     (IDX_W)
  ) u_slice_mux (
    .data_i(buf_data),
    .idx_i (idx),
    .data_o(ast_data_o)
  );

  assign ast_valid_o         = sending;
  assign ast_startofpacket_o = sending && buf_sop && (idx == '0);
  assign ast_endofpacket_o   = sending && buf_eop && last_slice;
  assign ast_empty_o         = (sending && buf_eop && last_slice) ?
                               EMPTY_OUT_W'(out_empty(buf_eop, int'(buf_empty), WORD_IN, WORD_OUT)) : '0;
  assign ast_channel_o       = buf_channel;

endmodule

// File: tb/tb_ast_width_narrower.sv
// Bench for ast_width_narrower: byte-level packet model feeds a scoreboard of
// expected narrow beats; a negedge monitor pops and compares them.
module tb_ast_width_narrower;

  logic         clk_i;
  logic         srst_i;
  logic [255:0] ast_data_i;
  logic         ast_startofpacket_i;
  logic         ast_endofpacket_i;
  logic         ast_valid_i;
  logic [4:0]   ast_empty_i;
  logic [9:0]   ast_channel_i;
  logic         ast_ready_o;
  logic [63:0]  ast_data_o;
  logic         ast_startofpacket_o;
  logic         ast_endofpacket_o;
  logic         ast_valid_o;
  logic [2:0]   ast_empty_o;
  logic [9:0]   ast_channel_o;
  logic         ast_ready_i;
`ifdef AST_WIDTH_NARROWER_ERR_EN
  logic         ast_err_o;
`endif

  ast_width_narrower dut (
    .clk_i              (clk_i),
    .srst_i             (srst_i),
    .ast_data_i         (ast_data_i),
    .ast_startofpacket_i(ast_startofpacket_i),
    .ast_endofpacket_i  (ast_endofpacket_i),
    .ast_valid_i        (ast_valid_i),
    .ast_empty_i        (ast_empty_i),
    .ast_channel_i      (ast_channel_i),
    .ast_ready_o        (ast_ready_o),
    .ast_data_o         (ast_data_o),
    .ast_startofpacket_o(ast_startofpacket_o),
    .ast_endofpacket_o  (ast_endofpacket_o),
    .ast_valid_o        (ast_valid_o),
    .ast_empty_o        (ast_empty_o),
    .ast_channel_o      (ast_channel_o),
    .ast_ready_i        (ast_ready_i)
`ifdef AST_WIDTH_NARROWER_ERR_EN
    ,
    .ast_err_o          (ast_err_o)
`endif
  );

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic [9:0]  chan;
    logic        last_in;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_miscmp = 0;
  int          n_pkts = 0;
  int          n_eop_out = 0;
  bit          chk_gaps = 0;
  bit          chk_ready = 1;
  int          rdy_mode = 0;
  logic [7:0]  pkt[256];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sink-side ready pattern: 0 always high, 1 two high / two low, 2 held low.
  initial begin
    int ph;
    ph = 0;
    ast_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
        0: ast_ready_i = 1'b1;
        1: begin
          ast_ready_i = (ph < 2);
          ph = (ph + 1) % 4;
        end
        default: ast_ready_i = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard pops, stall stability, ready and bubble checks.
  initial begin
    exp_t        e;
    bit          out_in_pkt;
    logic        prev_valid, prev_rdy, prev_srst;
    logic [63:0] prev_data;
    logic [14:0] prev_flags;
    out_in_pkt = 0;
    prev_valid = 0; prev_rdy = 0; prev_srst = 0;
    prev_data = '0; prev_flags = '0;
    forever begin
      @(negedge clk_i);
      if (prev_valid && !prev_rdy && prev_srst) begin
        check("hold_valid", 64'(ast_valid_o), 64'(1));
        check("hold_data", ast_data_o, prev_data);
        check("hold_flags", 64'({ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o}),
              64'(prev_flags));
      end
      if (srst_i && ast_valid_o && !ast_ready_i && chk_ready)
        check("ready_o_stall", 64'(ast_ready_o), 64'(0));
      if (chk_gaps && out_in_pkt && srst_i)
        check("no_bubble", 64'(ast_valid_o), 64'(1));
      if (srst_i && ast_valid_o && ast_ready_i) begin
        if (sb_q.size() == 0) begin
          check("unexpected_beat", 64'(ast_valid_o), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check("data", ast_data_o, e.data);
          check("sop", 64'(ast_startofpacket_o), 64'(e.sop));
          check("eop", 64'(ast_endofpacket_o), 64'(e.eop));
          check("empty", 64'(ast_empty_o), 64'(e.empty));
          check("channel", 64'(ast_channel_o), 64'(e.chan));
          if (chk_ready) check("ready_o_take", 64'(ast_ready_o), 64'(e.last_in));
        end
        if (ast_startofpacket_o) out_in_pkt = 1;
        if (ast_endofpacket_o) begin
          out_in_pkt = 0;
          n_eop_out++;
        end
      end
      if (!srst_i) out_in_pkt = 0;
      prev_valid = ast_valid_o;
      prev_rdy   = ast_ready_i;
      prev_srst  = srst_i;
      prev_data  = ast_data_o;
      prev_flags = {ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o};
    end
  end

  task automatic drive_beat(input logic [255:0] d, input logic sop, input logic eop,
                            input logic [4:0] emp, input logic [9:0] ch);
    int t;
    bit got;
    t = 0;
    got = 0;
    ast_data_i = d;
    ast_startofpacket_i = sop;
    ast_endofpacket_i = eop;
    ast_empty_i = emp;
    ast_channel_i = ch;
    ast_valid_i = 1'b1;
    while (!got && t < 200) begin
      @(negedge clk_i);
      got = ast_ready_o;
      @(posedge clk_i);
      #1;
      t++;
    end
    if (!got) check("accept_timeout", 64'(got), 64'(1));
    ast_valid_i = 1'b0;
  endtask

  // Four expected slices of one full wide beat.
  task automatic push_slices(input logic [255:0] d, input logic sop, input logic eop, input logic [9:0] ch);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.data = d[k*64 +: 64];
      e.sop = sop && (k == 0);
      e.eop = eop && (k == 3);
      e.empty = 3'd0;
      e.chan = ch;
      e.last_in = (k == 3);
      sb_q.push_back(e);
    end
  endtask

  task automatic send_packet(input int len, input logic [9:0] ch, input int gap);
    exp_t         e;
    int           nout, nin;
    logic [255:0] d;
    for (int i = 0; i < len; i++) pkt[i] = 8'($urandom);
    nout = (len + 7) / 8;
    for (int k = 0; k < nout; k++) begin
      e.data = '0;
      for (int i = 0; i < 8; i++)
        if (k*8 + i < len) e.data[i*8 +: 8] = pkt[k*8 + i];
      e.sop = (k == 0);
      e.eop = (k == nout - 1);
      e.empty = e.eop ? 3'(nout*8 - len) : 3'd0;
      e.chan = ch;
      e.last_in = e.eop || (k % 4 == 3);
      sb_q.push_back(e);
    end
    n_pkts++;
    nin = (len + 31) / 32;
    for (int b = 0; b < nin; b++) begin
      d = '0;
      for (int j = 0; j < 32; j++)
        if (b*32 + j < len) d[j*8 +: 8] = pkt[b*32 + j];
      drive_beat(d, b == 0, b == nin - 1, (b == nin - 1) ? 5'(nin*32 - len) : 5'd0, ch);
      if (gap > 0) begin
        repeat (gap) @(posedge clk_i);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    check("drain", 64'(sb_q.size()), 64'(0));
  endtask

  initial begin
    logic [255:0] d;
    srst_i = 1'b0;
    ast_data_i = '0;
    ast_startofpacket_i = 1'b0;
    ast_endofpacket_i = 1'b0;
    ast_valid_i = 1'b0;
    ast_empty_i = '0;
    ast_channel_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", 64'(ast_valid_o), 64'(0));
    check("rst_ready", 64'(ast_ready_o), 64'(0));
    check("rst_data", ast_data_o, 64'(0));
    check("rst_flags", 64'({ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o}), 64'(0));
`ifdef AST_WIDTH_NARROWER_ERR_EN
    check("rst_err", 64'(ast_err_o), 64'(0));
`endif
    @(posedge clk_i);
    #1;
    srst_i = 1'b1;
    @(negedge clk_i);
    check("idle_ready", 64'(ast_ready_o), 64'(1));
    @(posedge clk_i);
    #1;

    chk_gaps = 1;
    send_packet(128, 10'd0, 0);
    wait_drain();
    send_packet(132, 10'd3, 0);
    wait_drain();
    chk_gaps = 0;

    send_packet(1, 10'd7, 0);
    wait_drain();

    rdy_mode = 1;
    send_packet(40, 10'd5, 0);
    wait_drain();
    rdy_mode = 0;

    send_packet(96, 10'd2, 3);
    wait_drain();

    // Reset in the middle of a 64-byte packet while output is stalled.
    rdy_mode = 2;
    repeat (2) @(posedge clk_i);
    #1;
    d = {8{32'($urandom)}};
    drive_beat(d, 1'b1, 1'b0, 5'd0, 10'd9);
    ast_data_i = ~d;
    ast_startofpacket_i = 1'b0;
    ast_endofpacket_i = 1'b1;
    ast_valid_i = 1'b1;
    @(negedge clk_i);
    check("stall_ready_o", 64'(ast_ready_o), 64'(0));
    check("stall_valid_o", 64'(ast_valid_o), 64'(1));
    @(posedge clk_i);
    #1;
    srst_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("midrst_valid", 64'(ast_valid_o), 64'(0));
    check("midrst_ready", 64'(ast_ready_o), 64'(0));
    check("midrst_eop", 64'(ast_endofpacket_o), 64'(0));
    @(posedge clk_i);
    #1;
    srst_i = 1'b1;
    ast_valid_i = 1'b0;
    rdy_mode = 0;
    repeat (4) begin
      @(negedge clk_i);
      check("post_rst_idle", 64'(ast_valid_o), 64'(0));
    end
    @(posedge clk_i);
    #1;
    send_packet(32, 10'd1, 0);
    wait_drain();

`ifdef AST_WIDTH_NARROWER_ERR_EN
    chk_ready = 0;
    d = {8{32'($urandom)}};
    push_slices(d, 1'b1, 1'b0, 10'd4);
    drive_beat(d, 1'b1, 1'b0, 5'd0, 10'd4);
    drive_beat(~d, 1'b1, 1'b0, 5'd0, 10'd4);
    d = {8{32'($urandom)}};
    push_slices(d, 1'b0, 1'b1, 10'd4);
    drive_beat(d, 1'b0, 1'b1, 5'd0, 10'd4);
    n_pkts++;
    wait_drain();
    check("err_set", 64'(ast_err_o), 64'(1));
    repeat (5) @(posedge clk_i);
    #1;
    check("err_sticky", 64'(ast_err_o), 64'(1));
    chk_ready = 1;
`endif

    repeat (4) @(posedge clk_i);
    #1;
    check("eop_count", 64'(n_eop_out), 64'(n_pkts));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
